// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for one single-port synchronous RAM.
// Optional stall counters when ARB_PERF_CNT_EN is defined.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ready,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_ready,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_if_stall_cnt,
  output logic [31:0]     perf_d_stall_cnt
`endif
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_IF,
    RESP_D
  } resp_t;

  resp_t      state;
  resp_t      state_nxt;
  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       gnt_d;
  logic       gnt_if;
  logic       unused;

  assign unused = ^{if_addr[1:0], d_addr[1:0]};

  // Grant: data first unless a waiting fetch has hit the limit
  always_comb begin
    starve_hit = if_req && (starve_cnt == SMAX);
    gnt_d      = rst_n && d_req && !starve_hit;
    gnt_if     = rst_n && if_req && !gnt_d;
  end

  assign if_ready = gnt_if;
  assign d_ready  = gnt_d;

  // Mux the granted port onto the RAM
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt_d: begin
        mem_en    = 1'b1;
        mem_we    = d_we ? d_wstrb : '0;
        mem_addr  = {d_addr[AW-1:2], 2'b00};
        mem_wdata = d_wdata;
      end
      gnt_if: begin
        mem_en   = 1'b1;
        mem_addr = {if_addr[AW-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Consecutive data grants taken while a fetch is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (gnt_if || !if_req) begin
      starve_cnt <= '0;
    end else if (gnt_d && starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Owner of the read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESP_NONE;
    else        state <= state_nxt;
  end

  // Next owner from this cycle's grant; route read data to owner
  always_comb begin
    state_nxt = RESP_NONE;
    if (gnt_if)             state_nxt = RESP_IF;
    else if (gnt_d && !d_we) state_nxt = RESP_D;
    if_rvalid = (state == RESP_IF);
    d_rvalid  = (state == RESP_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

`ifdef ARB_PERF_CNT_EN
  // Stall cycle counters, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_stall_cnt <= '0;
      perf_d_stall_cnt  <= '0;
    end else begin
      if (if_req && !gnt_if)
        perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
      if (d_req && !gnt_d)
        perf_d_stall_cnt <= perf_d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter with a behavioural RAM
// and per-port read-data scoreboards.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall_cnt;
  logic [31:0] perf_d_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] ref_mem[256];
  logic [31:0] ram[256];
  logic [31:0] exp;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .AW(32), .DW(32), .STARVE_MAX(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_stall_cnt(perf_if_stall_cnt),
    .perf_d_stall_cnt(perf_d_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    return {8'hA5, 8'(i), 8'(i ^ 8'h5A), 8'(255 - i)};
  endfunction

  function automatic logic [31:0] merge(
    logic [31:0] old, logic [31:0] nw, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b])
          ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
    d_wdata = 32'h12345678; d_wstrb = 4'hF;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if_ready, d_ready, mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_grant got=%b want=000",
               {if_ready, d_ready, mem_en});
    end
    checks++;
    if (mem_we !== 4'h0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got we=%h a=%h wd=%h want 0",
               mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 ||
        if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_resp got iv=%b dv=%b ir=%h dr=%h want 0",
               if_rvalid, d_rvalid, if_rdata, d_rdata);
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (perf_if_stall_cnt !== 32'h0 || perf_d_stall_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_perf got if=%0d d=%0d want 0",
               perf_if_stall_cnt, perf_d_stall_cnt);
    end
`endif
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    d_wdata = '0; d_wstrb = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || if_rvalid !== 1'b0 ||
        d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got en=%b iv=%b dv=%b want 0",
               mem_en, if_rvalid, d_rvalid);
    end
  endtask

  task automatic test_fetch_only();
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1 || d_ready !== 1'b0) begin
      failures++;
      $display("FAIL fetch_grant got ir=%b dr=%b want 1 0",
               if_ready, d_ready);
    end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h10 ||
        mem_we !== 4'h0) begin
      failures++;
      $display("FAIL fetch_mem got en=%b a=%h we=%h want 1 10 0",
               mem_en, mem_addr, mem_we);
    end
    if_q.push_back(ref_mem[4]);
    @(posedge clk);
    #1 if_addr = 32'h13;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_q.size() == 0) begin
      failures++;
      $display("FAIL fetch_rvalid1 got=%b want=1", if_rvalid);
    end else begin
      exp = if_q.pop_front();
      if (if_rdata !== exp) begin
        failures++;
        $display("FAIL fetch_rdata1 got=%h want=%h", if_rdata, exp);
      end
    end
    checks++;
    if (mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL fetch_align got=%h want=10", mem_addr);
    end
    if_q.push_back(ref_mem[4]);
    @(posedge clk);
    #1 if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 ||
        if_q.size() == 0) begin
      failures++;
      $display("FAIL fetch_rvalid2 got iv=%b dv=%b want 1 0",
               if_rvalid, d_rvalid);
    end else begin
      exp = if_q.pop_front();
      if (if_rdata !== exp) begin
        failures++;
        $display("FAIL fetch_rdata2 got=%h want=%h", if_rdata, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL fetch_idle got iv=%b ir=%h want 0",
               if_rvalid, if_rdata);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40;
    d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1 || if_ready !== 1'b0 ||
        mem_we !== 4'hF || mem_wdata !== 32'hDEADBEEF ||
        mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL wr_drive got dr=%b we=%h wd=%h a=%h",
               d_ready, mem_we, mem_wdata, mem_addr);
    end
    ref_mem[16] = merge(ref_mem[16], 32'hDEADBEEF, 4'hF);
    @(posedge clk);
    #1 d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1 || mem_we !== 4'h0 ||
        d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_issue got dr=%b we=%h dv=%b want 1 0 0",
               d_ready, mem_we, d_rvalid);
    end
    d_q.push_back(32'hDEADBEEF);
    @(posedge clk);
    #1 d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 ||
        d_q.size() == 0) begin
      failures++;
      $display("FAIL rd_rvalid got dv=%b iv=%b want 1 0",
               d_rvalid, if_rvalid);
    end else begin
      exp = d_q.pop_front();
      if (d_rdata !== exp) begin
        failures++;
        $display("FAIL rd_rdata got=%h want=%h", d_rdata, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle got=%b want=0", d_rvalid);
    end
  endtask

  task automatic test_byte_strobe();
    @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80;
    d_wdata = 32'h11223344; d_wstrb = 4'hF;
    @(posedge clk);
    #1 d_wdata = 32'hAABBCCDD; d_wstrb = 4'b0010;
    @(negedge clk);
    checks++;
    if (mem_we !== 4'b0010 || mem_wdata !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL strb_drive got we=%b wd=%h want 0010 aabbccdd",
               mem_we, mem_wdata);
    end
    ref_mem[32] = merge(32'h11223344, 32'hAABBCCDD, 4'b0010);
    @(posedge clk);
    #1 d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
    d_q.push_back(32'h1122CC44);
    @(posedge clk);
    #1 d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_q.size() == 0) begin
      failures++;
      $display("FAIL strb_rvalid got=%b want=1", d_rvalid);
    end else begin
      exp = d_q.pop_front();
      if (d_rdata !== exp) begin
        failures++;
        $display("FAIL strb_rdata got=%h want=%h", d_rdata, exp);
      end
    end
  endtask

  task automatic test_contention();
    logic [9:0]  pat;
    logic        prev_if;
    logic [31:0] if0;
    logic [31:0] d0;
    pat = 10'b1000010000;
    prev_if = 1'b0;
    if0 = '0;
    d0 = '0;
`ifdef ARB_PERF_CNT_EN
    if0 = perf_if_stall_cnt;
    d0 = perf_d_stall_cnt;
`endif
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== pat[i] || d_ready !== !pat[i]) begin
        failures++;
        $display("FAIL cont_grant%0d got if=%b d=%b want if=%b",
                 i, if_ready, d_ready, pat[i]);
      end
      checks++;
      if (mem_addr !== (pat[i] ? 32'h20 : 32'h30)) begin
        failures++;
        $display("FAIL cont_addr%0d got=%h", i, mem_addr);
      end
      if (i > 0) begin
        checks++;
        if (prev_if) begin
          if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 ||
              if_q.size() == 0) begin
            failures++;
            $display("FAIL cont_ifresp%0d got iv=%b dv=%b",
                     i, if_rvalid, d_rvalid);
          end else begin
            exp = if_q.pop_front();
            if (if_rdata !== exp) begin
              failures++;
              $display("FAIL cont_ifdata%0d got=%h want=%h",
                       i, if_rdata, exp);
            end
          end
        end else begin
          if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 ||
              d_q.size() == 0) begin
            failures++;
            $display("FAIL cont_dresp%0d got dv=%b iv=%b",
                     i, d_rvalid, if_rvalid);
          end else begin
            exp = d_q.pop_front();
            if (d_rdata !== exp) begin
              failures++;
              $display("FAIL cont_ddata%0d got=%h want=%h",
                       i, d_rdata, exp);
            end
          end
        end
      end
      if (pat[i]) if_q.push_back(ref_mem[8]);
      else        d_q.push_back(ref_mem[12]);
      prev_if = pat[i];
    end
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_q.size() == 0) begin
      failures++;
      $display("FAIL cont_lastresp got=%b want=1", if_rvalid);
    end else begin
      exp = if_q.pop_front();
      if (if_rdata !== exp) begin
        failures++;
        $display("FAIL cont_lastdata got=%h want=%h", if_rdata, exp);
      end
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (perf_if_stall_cnt - if0 !== 32'd8 ||
        perf_d_stall_cnt - d0 !== 32'd2) begin
      failures++;
      $display("FAIL cont_perf got if=%0d d=%0d want 8 2",
               perf_if_stall_cnt - if0, perf_d_stall_cnt - d0);
    end
`else
    if (if0 != d0) $display("note: unexpected perf snapshot");
`endif
  endtask

  task automatic test_reset_mid_read();
    // Fetch read granted, reset before its data returns
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h10;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 ||
        if_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_if got iv=%b ir=%h rdy=%b want 0",
               if_rvalid, if_rdata, if_ready);
    end
    if_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after%0d got iv=%b dv=%b want 0",
                 i, if_rvalid, d_rvalid);
      end
    end
    // Starve count at 3 and a data read in flight, then reset
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (d_rvalid !== 1'b0 || d_ready !== 1'b0 ||
        if_ready !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_d got dv=%b dr=%b ir=%b en=%b",
               d_rvalid, d_ready, if_ready, mem_en);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== (i == 4) || d_ready !== (i != 4)) begin
        failures++;
        $display("FAIL rstmid_cnt%0d got if=%b d=%b want if=%b",
                 i, if_ready, d_ready, i == 4);
      end
    end
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_write_read();
    test_byte_strobe();
    test_contention();
    test_reset_mid_read();
    checks++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got if=%0d d=%0d want 0 0",
               if_q.size(), d_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
